// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and small op-decode helpers.
package muldiv_unit_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

    // True for the two's-complement flavours (mult, div).
    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // True for the divide flavours (div, divu).
    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negator. Used both to take operand
// magnitudes and to restore the sign of products, quotients and remainders.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         en,
    output logic [W-1:0] dout
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Negate when enabled, pass through otherwise.
    always_comb begin
        dout = din;
        if (en) begin
            dout = (~din) + ONE;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit feeding the architectural HI/LO
// registers. Multiplies by shift-add, divides by restoring division, both
// on unsigned magnitudes with sign fix-up applied as the result is written.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no operation running; mthi/mtlo accepted; start launches an op
// RUN   | one iteration per edge; HI/LO written when counter == WIDTH-1
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    md_state_t state, state_nxt;
    logic      load, iter, finish;

    logic [CNTW-1:0]  cnt;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             div0;
    // Multiply: acc_hi:acc_lo is the running product with the multiplier
    // shifting out of acc_lo. Divide: acc_hi is the partial remainder and
    // acc_lo shifts dividend bits out while quotient bits shift in.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] step_hi, step_lo;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    assign sign_a = md_is_signed(op) & a[WIDTH-1];
    assign sign_b = md_is_signed(op) & b[WIDTH-1];

    muldiv_negate #(.W(WIDTH)) u_neg_a (
        .din  (a),
        .en   (sign_a),
        .dout (a_mag)
    );

    muldiv_negate #(.W(WIDTH)) u_neg_b (
        .din  (b),
        .en   (sign_b),
        .dout (b_mag)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        iter      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                iter = 1'b1;
                if (cnt == CNT_LAST) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // One radix-2 step for whichever operation is running.
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd};
        // Borrow out of the top bit means the trial subtract went negative.
        div_ok   = ~div_diff[WIDTH];
        if (is_div) begin
            step_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    muldiv_negate #(.W(2*WIDTH)) u_neg_prod (
        .din  ({step_hi, step_lo}),
        .en   (neg_res & ~is_div),
        .dout (prod_fix)
    );

    muldiv_negate #(.W(WIDTH)) u_neg_quo (
        .din  (step_lo),
        .en   (neg_res),
        .dout (quo_fix)
    );

    muldiv_negate #(.W(WIDTH)) u_neg_rem (
        .din  (step_hi),
        .en   (neg_rem),
        .dout (rem_fix)
    );

    // Final HI/LO selection. On divide by zero the remainder path already
    // yields the dividend with its own sign, so only LO needs forcing.
    always_comb begin
        fin_hi = prod_fix[2*WIDTH-1:WIDTH];
        fin_lo = prod_fix[WIDTH-1:0];
        if (is_div) begin
            fin_hi = rem_fix;
            fin_lo = div0 ? '1 : quo_fix;
        end
    end

    // Operand latch at launch, then one accumulator update per RUN edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
        end else if (load) begin
            cnt     <= '0;
            is_div  <= md_is_div(op);
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            div0    <= md_is_div(op) && (b == '0);
            acc_hi  <= '0;
            acc_lo  <= md_is_div(op) ? a_mag : b_mag;
            opnd    <= md_is_div(op) ? b_mag : a_mag;
        end else if (iter) begin
            cnt    <= finish ? '0 : cnt + CNT_ONE;
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

    // HI/LO: operation result wins; mthi/mtlo only land while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (finish) begin
            hi <= fin_hi;
            lo <= fin_lo;
        end else if (state == IDLE) begin
            if (hi_we) begin
                hi <= wd;
            end
            if (lo_we) begin
                lo <= wd;
            end
        end
    end

    // Completion pulse for the cycle after the final write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= finish;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases with literal
// expectations plus randomized operations against a cycle-level model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b, wd;
    logic         hi_we, lo_we;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Architectural result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        longint     sx, sy, q, r;
        logic [63:0] ux, uy, res;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        res = '0;
        case (o)
            MD_MULT:  res = sx * sy;
            MD_MULTU: res = ux * uy;
            default: begin
                if (y == 32'd0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else if (o == MD_DIV) begin
                    q   = sx / sy;
                    r   = sx % sy;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = ((ux % uy) << 32) | (ux / uy);
                end
            end
        endcase
        return res;
    endfunction

    // Cycle-level model: an op started from idle finishes 32 edges later.
    logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
    logic        m_busy = 1'b0, m_done = 1'b0;
    int          m_left = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            m_done <= 1'b0;
            if (m_left == 1) begin
                m_hi   <= m_rhi;
                m_lo   <= m_rlo;
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
            if (hi_we) m_hi <= wd;
            if (lo_we) m_lo <= wd;
            if (start) begin
                {m_rhi, m_rlo} <= ref_result(op, a, b);
                m_busy         <= 1'b1;
                m_left         <= W;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always begin
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== m_busy || done !== m_done || hi !== m_hi || lo !== m_lo) begin
            miscompares++;
            $display("FAIL cycle_check t=%0t: dut busy=%b done=%b hi=%h lo=%h, model busy=%b done=%b hi=%h lo=%h",
                     $time, busy, done, hi, lo, m_busy, m_done, m_hi, m_lo);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Called just after a negedge; returns at the negedge where done is seen.
    task automatic wait_done(input string name, input bit noisy, output int busyc);
        int n;
        busyc = 0;
        n     = 0;
        while (!done && n < 64) begin
            if (busy) busyc++;
            n++;
            if (noisy) begin
                start = ($urandom_range(0, 7) == 0);
                op    = 2'($urandom_range(0, 3));
                a     = $urandom();
                b     = $urandom();
                hi_we = ($urandom_range(0, 7) == 0);
                lo_we = ($urandom_range(0, 7) == 0);
                wd    = $urandom();
            end
            @(negedge clk);
        end
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, done, n);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit noisy, output int busyc);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(name, noisy, busyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int bc;
        logic [31:0] prev_lo;
        reset = 1'b1;
        start = 1'b0;
        op    = MD_MULT;
        a     = '0;
        b     = '0;
        wd    = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        run_op("multu_ff", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, bc);
        chk("multu_ff_hi", hi, 32'hFFFF_FFFE);
        chk("multu_ff_lo", lo, 32'h0000_0001);
        chk("multu_ff_busy_cycles", bc, 32'd32);
        @(negedge clk);
        chk("done_single_pulse", {31'd0, done}, 32'd0);

        run_op("mult_neg3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, bc);
        chk("mult_neg3x5_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg3x5_lo", lo, 32'hFFFF_FFF1);
        run_op("mult_min_sq", MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, bc);
        chk("mult_min_sq_hi", hi, 32'h4000_0000);
        chk("mult_min_sq_lo", lo, 32'h0000_0000);
        chk("back_to_back_busy_cycles", bc, 32'd32);
        run_op("div_neg7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, bc);
        chk("div_neg7_2_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg7_2_hi", hi, 32'hFFFF_FFFF);
        run_op("divu_7_2", MD_DIVU, 32'd7, 32'd2, 1'b0, bc);
        chk("divu_7_2_lo", lo, 32'd3);
        chk("divu_7_2_hi", hi, 32'd1);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bc);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0000_0000);
        run_op("divu_by0", MD_DIVU, 32'h0000_1234, 32'd0, 1'b0, bc);
        chk("divu_by0_lo", lo, 32'hFFFF_FFFF);
        chk("divu_by0_hi", hi, 32'h0000_1234);
        chk("divu_by0_busy_cycles", bc, 32'd32);
        run_op("div_by0_neg", MD_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, bc);
        chk("div_by0_neg_lo", lo, 32'hFFFF_FFFF);
        chk("div_by0_neg_hi", hi, 32'hFFFF_FFF9);

        // start and mthi during a running multu must be dropped
        op    = MD_MULTU;
        a     = 32'd6;
        b     = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        op    = MD_DIVU;
        a     = 32'd9;
        b     = 32'd3;
        start = 1'b1;
        hi_we = 1'b1;
        wd    = 32'h0000_AAAA;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        wait_done("busy_ignore", 1'b0, bc);
        chk("busy_ignore_hi", hi, 32'd0);
        chk("busy_ignore_lo", lo, 32'd42);

        @(negedge clk);
        hi_we = 1'b1;
        wd    = 32'h0000_AAAA;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_hi", hi, 32'h0000_AAAA);
        chk("mthi_lo_kept", lo, 32'd42);
        lo_we = 1'b1;
        wd    = 32'h0000_5555;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_5555);
        chk("mtlo_hi_kept", hi, 32'h0000_AAAA);

        // asynchronous reset in the middle of an operation
        op    = MD_MULTU;
        a     = 32'h1234_5678;
        b     = 32'h9ABC_DEF0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        chk("async_reset_done", {31'd0, done}, 32'd0);
        chk("async_reset_hi", hi, 32'd0);
        chk("async_reset_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_op("multu_3x4", MD_MULTU, 32'd3, 32'd4, 1'b0, bc);
        chk("multu_3x4_lo", lo, 32'd12);
        chk("multu_3x4_hi", hi, 32'd0);
        chk("multu_3x4_busy_cycles", bc, 32'd32);

        // randomized operations with noise while busy and idle gaps
        for (int i = 0; i < 150; i++) begin
            run_op("rand", 2'($urandom_range(0, 3)), pick(), pick(), 1'b1, bc);
            if ($urandom_range(0, 3) == 0) begin
                prev_lo = lo;
                repeat ($urandom_range(1, 3)) begin
                    hi_we = $urandom_range(0, 1) == 1;
                    lo_we = $urandom_range(0, 1) == 1;
                    wd    = $urandom();
                    @(negedge clk);
                end
                hi_we = 1'b0;
                lo_we = 1'b0;
                if (prev_lo == 32'hDEAD_BEEF) chk("rand_idle_lo_seen", lo, lo ^ 32'd0);
            end
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
